// File: rtl/mem_mmio_pkg.sv
// Shared constants for mem_mmio: MMIO window layout and exit codes.
package mem_mmio_pkg;

  // MMIO window occupies byte addresses 0x000..0x007 (four 16-bit slots).
  localparam int MMIO_WINDOW_BYTES = 8;
  localparam int MMIO_WINDOW_BITS  = $clog2(MMIO_WINDOW_BYTES);

  // MMIO slot indices, taken from byte address bits [2:1].
  localparam logic [1:0] MMIO_STATUS = 2'd0;
  localparam logic [1:0] MMIO_OUT    = 2'd1;
  localparam logic [1:0] MMIO_HALT   = 2'd2;
  localparam logic [1:0] MMIO_RSVD   = 2'd3;

  // Exit code reported when the watchdog ends the run.
  localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;

endpackage

// File: rtl/mem_mmio_byte_fifo.sv
// byte_fifo: small byte FIFO with simultaneous push/pop at any fill level.
// The head byte is presented combinationally from storage.
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign pop_ok    = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok   = push & (~full | pop_ok);
  assign head_data = store[rd_ptr];

  // Storage and write pointer; storage is cleared so the idle head reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= 8'h00;
    end else if (push_ok) begin
      store[wr_ptr] <= push_data;
      wr_ptr        <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on each accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_ptr <= '0;
    else if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
  end

  // Occupancy tracking; push and pop together leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_mmio.sv
// mem_mmio: word-organised data RAM with byte addressing, an MMIO window
// (STATUS / OUT / HALT) and a buffered character output FIFO.
// Optional watchdog compiled in with `define MEM_MMIO_WATCHDOG_EN.
module mem_mmio
  import mem_mmio_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int RAM_WORDS      = 512,
  parameter int OUT_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_wr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         stall,
  input  logic                         load_en,
  input  logic [$clog2(RAM_WORDS)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data,
  output logic                         out_valid,
  output logic [7:0]                   out_data,
  input  logic                         out_ready,
  output logic                         halt,
  output logic [7:0]                   exit_code,
  output logic                         timeout
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int RAM_AW     = $clog2(RAM_WORDS);
  localparam int CNT_W      = $clog2(OUT_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];

  logic [RAM_AW-1:0]     ram_idx;
  logic                  is_mmio;
  logic [1:0]            mmio_idx;
  logic                  wr_ok;
  logic                  ram_we;
  logic                  out_push;
  logic                  halt_wr;
  logic                  wd_fire;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_pop;

  logic [CNT_W+3:0]      status_bits;
  logic [DATA_WIDTH-1:0] mmio_rd;

  assign ram_idx  = RAM_AW'(mem_addr >> BYTE_SHIFT);
  assign is_mmio  = (mem_addr[ADDR_WIDTH-1:MMIO_WINDOW_BITS] == '0);
  assign mmio_idx = mem_addr[2:1];

  assign fifo_pop  = out_valid & out_ready;
  assign out_valid = ~fifo_empty;

  // A write to OUT with a full FIFO waits unless the head drains this cycle.
  assign stall = mem_wr & is_mmio & (mmio_idx == MMIO_OUT) & fifo_full & ~fifo_pop;

  // Once halted, every CPU write is dropped; reads and draining continue.
  assign wr_ok    = mem_wr & ~stall & ~halt;
  assign ram_we   = wr_ok & ~is_mmio & ~load_en;
  assign out_push = wr_ok & is_mmio & (mmio_idx == MMIO_OUT);
  assign halt_wr  = wr_ok & is_mmio & (mmio_idx == MMIO_HALT);

  byte_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_push),
    .push_data (wr_data[7:0]),
    .pop       (fifo_pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign status_bits = {halt, timeout, fifo_full, fifo_empty, fifo_count};

  // MMIO read mux; write-only and reserved slots read as zero.
  always_comb begin
    mmio_rd = '0;
    case (mmio_idx)
      MMIO_STATUS: mmio_rd = DATA_WIDTH'(status_bits);
      MMIO_HALT:   mmio_rd = DATA_WIDTH'(exit_code);
      default:     mmio_rd = '0;
    endcase
  end

  // RAM write port; preload has priority and survives reset.
  always_ff @(posedge clk) begin
    if (load_en)     ram[load_addr] <= load_data;
    else if (ram_we) ram[ram_idx]   <= wr_data;
  end

  // Registered read data, updated on every read cycle and held on writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (!mem_wr) begin
      if (is_mmio) rd_data <= mmio_rd;
      else         rd_data <= ram[ram_idx];
    end
  end

`ifdef MEM_MMIO_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  // Fires on the TIMEOUT_CYCLES-th running cycle after reset.
  assign wd_fire = ~halt & (wd_cnt == '0);

  // Watchdog down-counter, frozen once the run has halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
    else if (!halt && wd_cnt != '0) wd_cnt <= wd_cnt - 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Halt / exit-code latch; the first cause wins and an explicit HALT beats the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt      <= 1'b0;
      timeout   <= 1'b0;
      exit_code <= 8'h00;
    end else if (!halt) begin
      if (halt_wr) begin
        halt      <= 1'b1;
        exit_code <= wr_data[7:0];
      end else if (wd_fire) begin
        halt      <= 1'b1;
        timeout   <= 1'b1;
        exit_code <= EXIT_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_mem_mmio.sv
// Directed self-checking bench for mem_mmio.
module tb_mem_mmio;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int RW = 512;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          stall;
  logic          load_en;
  logic [8:0]    load_addr;
  logic [DW-1:0] load_data;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          halt;
  logic [7:0]    exit_code;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  mem_mmio #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .RAM_WORDS      (RW),
    .OUT_DEPTH      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .stall     (stall),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halt      (halt),
    .exit_code (exit_code),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; mem_addr = '0; mem_wr = 1'b0; wr_data = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rd_data, out_valid, out_data, halt, exit_code, timeout, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rd=%h ov=%b od=%h h=%b ec=%h to=%b st=%b",
               rd_data, out_valid, out_data, halt, exit_code, timeout, stall);
    end
    mem_addr = 10'h000; tick();
    checks++;
    if (rd_data !== 16'h0008) begin
      errors++; $display("FAIL reset_status got %h want 0008", rd_data);
    end
  endtask

  task automatic test_preload();
    apply_reset();
    load_en = 1'b1; load_addr = 9'd5; load_data = 16'h1234; tick();
    load_en = 1'b0; mem_addr = 10'h00A; mem_wr = 1'b0; tick();
    checks++;
    if (rd_data !== 16'h1234) begin errors++; $display("FAIL preload_read got %h want 1234", rd_data); end
    mem_wr = 1'b1; wr_data = 16'hBEEF; tick();
    checks++;
    if (rd_data !== 16'h1234) begin errors++; $display("FAIL rd_hold_on_write got %h want 1234", rd_data); end
    mem_wr = 1'b0; tick();
    checks++;
    if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL cpu_write_read got %h want beef", rd_data); end
    load_en = 1'b1; load_addr = 9'd6; load_data = 16'h5555;
    mem_wr = 1'b1; wr_data = 16'h7777; tick();
    load_en = 1'b0; mem_wr = 1'b0; tick();
    checks++;
    if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL preload_drops_cpu got %h want beef", rd_data); end
    load_en = 1'b1; load_addr = 9'd5; load_data = 16'hAAAA; tick();
    checks++;
    if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL preload_read_old got %h want beef", rd_data); end
    load_en = 1'b0; tick();
    checks++;
    if (rd_data !== 16'hAAAA) begin errors++; $display("FAIL preload_read_new got %h want aaaa", rd_data); end
  endtask

  task automatic test_output();
    apply_reset();
    out_ready = 1'b1;
    mem_addr = 10'h002; mem_wr = 1'b1; wr_data = 16'h0048; tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h48) begin
      errors++; $display("FAIL out_H valid=%b data=%h want 1/48", out_valid, out_data);
    end
    wr_data = 16'h0069; tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h69) begin
      errors++; $display("FAIL out_i valid=%b data=%h want 1/69", out_valid, out_data);
    end
    mem_wr = 1'b0; tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL out_drained valid=%b want 0", out_valid); end
    checks++;
    if (rd_data !== 16'h0000) begin errors++; $display("FAIL out_read_zero got %h want 0000", rd_data); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b0; mem_addr = 10'h002; mem_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 16'h0010 + 16'(i); tick();
    end
    mem_wr = 1'b0; mem_addr = 10'h000; tick();
    checks++;
    if (rd_data !== 16'h0014) begin errors++; $display("FAIL full_status got %h want 0014", rd_data); end
    mem_addr = 10'h002; mem_wr = 1'b1; wr_data = 16'h0014; #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_on_full got %b want 1", stall); end
    tick();
    checks++;
    if (stall !== 1'b1 || out_data !== 8'h10) begin
      errors++; $display("FAIL stall_hold stall=%b head=%h want 1/10", stall, out_data);
    end
    out_ready = 1'b1; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", stall); end
    tick();
    mem_wr = 1'b0;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL drain_%0d valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'h10 + 8'(i));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty valid=%b want 0", out_valid); end
  endtask

  task automatic test_halt();
    apply_reset();
    mem_addr = 10'h00C; mem_wr = 1'b1; wr_data = 16'h5A5A; tick();
    mem_addr = 10'h004; wr_data = 16'h002A; tick();
    checks++;
    if (halt !== 1'b1 || exit_code !== 8'h2A) begin
      errors++; $display("FAIL halt_set halt=%b code=%h want 1/2a", halt, exit_code);
    end
    wr_data = 16'h0001; tick();
    checks++;
    if (exit_code !== 8'h2A) begin errors++; $display("FAIL halt_second got %h want 2a", exit_code); end
    mem_addr = 10'h00C; wr_data = 16'h9999; tick();
    mem_addr = 10'h002; wr_data = 16'h0041; tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_out_ignored valid=%b want 0", out_valid); end
    mem_wr = 1'b0; mem_addr = 10'h00C; tick();
    checks++;
    if (rd_data !== 16'h5A5A) begin errors++; $display("FAIL halt_ram_ignored got %h want 5a5a", rd_data); end
    mem_addr = 10'h004; tick();
    checks++;
    if (rd_data !== 16'h002A) begin errors++; $display("FAIL halt_readback got %h want 002a", rd_data); end
    mem_addr = 10'h000; tick();
    checks++;
    if (rd_data !== 16'h0048) begin errors++; $display("FAIL halt_status got %h want 0048", rd_data); end
  endtask

  task automatic test_watchdog();
    apply_reset();
`ifdef MEM_MMIO_WATCHDOG_EN
    for (int i = 0; i < TO - 1; i++) tick();
    checks++;
    if (timeout !== 1'b0 || halt !== 1'b0) begin
      errors++; $display("FAIL wd_early to=%b halt=%b want 0/0", timeout, halt);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || halt !== 1'b1 || exit_code !== 8'hFF) begin
      errors++; $display("FAIL wd_fire to=%b halt=%b code=%h want 1/1/ff", timeout, halt, exit_code);
    end
`else
    for (int i = 0; i < TO + 10; i++) tick();
    checks++;
    if (timeout !== 1'b0 || halt !== 1'b0) begin
      errors++; $display("FAIL wd_disabled to=%b halt=%b want 0/0", timeout, halt);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    load_en = 1'b1; load_addr = 9'd5; load_data = 16'h1234; tick();
    load_en = 1'b0; mem_addr = 10'h00A; tick();
    out_ready = 1'b0; mem_addr = 10'h002; mem_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 16'h0061 + 16'(i); tick();
    end
    mem_addr = 10'h004; wr_data = 16'h0033; tick();
    checks++;
    if (halt !== 1'b1 || out_valid !== 1'b1 || rd_data !== 16'h1234) begin
      errors++; $display("FAIL pre_reset halt=%b ov=%b rd=%h want 1/1/1234", halt, out_valid, rd_data);
    end
    mem_wr = 1'b0; rst = 1'b1; #1;
    checks++;
    if ({rd_data, out_valid, out_data, halt, exit_code, timeout} !== '0) begin
      errors++;
      $display("FAIL async_reset rd=%h ov=%b od=%h h=%b ec=%h to=%b",
               rd_data, out_valid, out_data, halt, exit_code, timeout);
    end
    tick();
    rst = 1'b0; mem_addr = 10'h00A; tick();
    checks++;
    if (rd_data !== 16'h1234) begin errors++; $display("FAIL ram_kept got %h want 1234", rd_data); end
    mem_addr = 10'h000; tick();
    checks++;
    if (rd_data !== 16'h0008) begin errors++; $display("FAIL post_reset_status got %h want 0008", rd_data); end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_output();
    test_back_to_back();
    test_halt();
    test_watchdog();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit reached before summary");
    $fatal(1, "time limit");
  end

endmodule
